// File: rtl/exec_ctrl_if.sv
// Bus bundle for exec_ctrl: instruction handshake, ALU issue/result, writeback and debug read.
// The slave modport is the controller's view; master is the environment (ALU, fetch, debug).
interface exec_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_enable;
    logic [3:0]  opcode;
    logic [15:0] operand_one;
    logic [15:0] operand_two;
    logic [15:0] result;
    logic        alu_done;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        illegal;
    logic        busy;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    modport master (
        output instr, instr_valid, result, alu_done, dbg_addr,
        input  instr_ready, alu_enable, opcode, operand_one, operand_two,
               wb_valid, wb_rd, wb_data, illegal, busy, dbg_data
    );

    modport slave (
        input  instr, instr_valid, result, alu_done, dbg_addr,
        output instr_ready, alu_enable, opcode, operand_one, operand_two,
               wb_valid, wb_rd, wb_data, illegal, busy, dbg_data
    );
endinterface

// File: rtl/exec_ctrl.sv
// Single-issue execute controller: decodes one instruction, issues it to an external ALU and
// writes the result back into an 8 x 16-bit register file. Optional macro EXEC_CTRL_DIV_ZERO_TRAP_EN.
module exec_ctrl #(
    parameter int NREGS = 8
) (
    input  logic         clk,
    input  logic         reset,
    exec_ctrl_if.slave   bus
`ifdef EXEC_CTRL_DIV_ZERO_TRAP_EN
    ,
    output logic         div_zero
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] regs [NREGS];
    logic [3:0]  opcode_q;
    logic [2:0]  rd_q;
    logic [15:0] op_one_q;
    logic [15:0] op_two_q;
    logic [15:0] res_q;

    logic        accept;
    logic        bad_op;
    logic        trap;
    logic        imm_form;
    logic [3:0]  new_opc;

    assign accept   = (state == IDLE) && bus.instr_valid;
    assign new_opc  = bus.instr[15:12];
    assign imm_form = !new_opc[3] && new_opc[0];

    assign bad_op = (opcode_q == 4'b1000) || (opcode_q == 4'b1001) ||
                    (opcode_q == 4'b1010) || (opcode_q == 4'b1111);

`ifdef EXEC_CTRL_DIV_ZERO_TRAP_EN
    assign trap = ((opcode_q == 4'b0110) || (opcode_q == 4'b0111)) && (op_two_q == 16'd0);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Trapped and illegal opcodes drop straight back to IDLE without touching the ALU.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.instr_valid) next_state = ISSUE;
            ISSUE:   next_state = (bad_op || trap) ? IDLE : WAIT;
            WAIT:    if (bus.alu_done) next_state = WB;
            WB:      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.instr_ready = (state == IDLE);
        bus.busy        = (state != IDLE);
        bus.alu_enable  = (state == ISSUE) && !bad_op && !trap;
        bus.illegal     = (state == ISSUE) && bad_op;
        bus.wb_valid    = (state == WB);
`ifdef EXEC_CTRL_DIV_ZERO_TRAP_EN
        div_zero        = (state == ISSUE) && trap;
`endif
    end

    // Operands are captured at the accept edge so they are valid throughout ISSUE, WAIT and WB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q <= 4'd0;
            rd_q     <= 3'd0;
            op_one_q <= 16'd0;
            op_two_q <= 16'd0;
            res_q    <= 16'd0;
        end else begin
            if (accept) begin
                opcode_q <= new_opc;
                rd_q     <= bus.instr[11:9];
                op_one_q <= regs[bus.instr[8:6]];
                op_two_q <= imm_form ? {10'd0, bus.instr[5:0]} : regs[bus.instr[5:3]];
            end
            if ((state == WAIT) && bus.alu_done) begin
                res_q <= bus.result;
            end
        end
    end

    // Entry 0 is never written, so it reads as zero without a special read path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 16'd0;
            end
        end else if ((state == WB) && (rd_q != 3'd0)) begin
            regs[rd_q] <= res_q;
        end
    end

    assign bus.opcode      = opcode_q;
    assign bus.operand_one = op_one_q;
    assign bus.operand_two = op_two_q;
    assign bus.wb_rd       = rd_q;
    assign bus.wb_data     = res_q;
    assign bus.dbg_data    = regs[bus.dbg_addr];

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: acts as fetch, ALU and debug reader, checks hand-computed values.
module tb_exec_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef EXEC_CTRL_DIV_ZERO_TRAP_EN
    logic div_zero;
`endif

    exec_ctrl_if ifc();

    exec_ctrl #(.NREGS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (ifc)
`ifdef EXEC_CTRL_DIV_ZERO_TRAP_EN
        ,
        .div_zero (div_zero)
`endif
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount = 0;
    int cycleCount = 0;
    int aluDelay = 0;
    int acceptCycle = 0;
    int aluCount = 0;
    int aluCycle = 0;
    int wbCount = 0;
    int wbCycle = 0;
    int illegalCount = 0;
    int divZeroCount = 0;
    int firstAccept = 0;
    logic [15:0] aluOp1, aluOp2, wbData, wbOp1, wbOp2, rdVal;
    logic [3:0]  aluOpc;
    logic [2:0]  wbRd;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] aluModel(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b);
        case (opc)
            4'd0, 4'd1: return a + b;
            4'd2, 4'd3: return a - b;
            4'd4, 4'd5: return a * b;
            4'd6, 4'd7: return (b == 16'd0) ? 16'hFFFF : a / b;
            default:    return a ^ b;
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cycleCount++;
    end

    // ALU stand-in: answers each issue after aluDelay extra cycles and drops done after writeback.
    initial begin
        ifc.result = 16'd0;
        ifc.alu_done = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.alu_enable) begin
                int n;
                ifc.result = aluModel(ifc.opcode, ifc.operand_one, ifc.operand_two);
                n = 0;
                while (n < aluDelay && ifc.busy) begin
                    @(negedge clk);
                    n++;
                end
                ifc.alu_done = 1'b1;
                n = 0;
                while (!ifc.wb_valid && ifc.busy && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                ifc.alu_done = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (ifc.alu_enable) begin
                aluCount++;
                aluCycle = cycleCount;
                aluOp1 = ifc.operand_one;
                aluOp2 = ifc.operand_two;
                aluOpc = ifc.opcode;
            end
            if (ifc.wb_valid) begin
                wbCount++;
                wbCycle = cycleCount;
                wbRd = ifc.wb_rd;
                wbData = ifc.wb_data;
                wbOp1 = ifc.operand_one;
                wbOp2 = ifc.operand_two;
            end
            if (ifc.illegal) illegalCount++;
`ifdef EXEC_CTRL_DIV_ZERO_TRAP_EN
            if (div_zero) divZeroCount++;
`endif
        end
    end

    task automatic applyStimulus(input logic [15:0] word);
        int n;
        n = 0;
        @(negedge clk);
        ifc.instr = word;
        ifc.instr_valid = 1'b1;
        while (!ifc.instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("accept_timeout", 32'd0, 32'd1);
        acceptCycle = cycleCount;
        aluCount = 0;
        wbCount = 0;
        illegalCount = 0;
        divZeroCount = 0;
        @(posedge clk);
        #1;
        ifc.instr_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (!ifc.instr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic readReg(input logic [2:0] addr, output logic [15:0] value);
        ifc.dbg_addr = addr;
        #1;
        value = ifc.dbg_data;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed running expected finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        ifc.instr = 16'd0;
        ifc.instr_valid = 1'b0;
        ifc.dbg_addr = 3'd1;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", ifc.instr_ready, 1);
        checkOutput("rst_busy", ifc.busy, 0);
        checkOutput("rst_alu_en", ifc.alu_enable, 0);
        checkOutput("rst_wb_valid", ifc.wb_valid, 0);
        checkOutput("rst_illegal", ifc.illegal, 0);
        checkOutput("rst_opcode", ifc.opcode, 0);
        checkOutput("rst_op1", ifc.operand_one, 0);
        checkOutput("rst_op2", ifc.operand_two, 0);
        checkOutput("rst_wb_rd", ifc.wb_rd, 0);
        checkOutput("rst_wb_data", ifc.wb_data, 0);
        checkOutput("rst_dbg_r1", ifc.dbg_data, 0);
        reset = 1'b0;

        // ADDI r1,r0,5
        applyStimulus(16'h1205);
        waitIdle();
        checkOutput("addi_alu_count", aluCount, 1);
        checkOutput("addi_alu_lat", aluCycle - acceptCycle, 1);
        checkOutput("addi_opcode", aluOpc, 4'h1);
        checkOutput("addi_op1", aluOp1, 0);
        checkOutput("addi_op2", aluOp2, 5);
        checkOutput("addi_wb_lat", wbCycle - acceptCycle, 3);
        checkOutput("addi_wb_rd", wbRd, 1);
        checkOutput("addi_wb_data", wbData, 5);
        readReg(3'd1, rdVal);
        checkOutput("addi_dbg_r1", rdVal, 5);

        // ADDI r2,r0,3
        applyStimulus(16'h1403);
        waitIdle();
        readReg(3'd2, rdVal);
        checkOutput("addi_dbg_r2", rdVal, 3);

        // SUB r3,r1,r2 then MUL r4,r3,r1 back to back, valid held while busy
        applyStimulus(16'h2650);
        checkOutput("sub_opcode", ifc.opcode, 4'h2);
        checkOutput("sub_op2_reg", ifc.operand_two, 3);
        firstAccept = acceptCycle;
        applyStimulus(16'h48C8);
        checkOutput("b2b_spacing", acceptCycle - firstAccept, 4);
        checkOutput("mul_op1_fwd", ifc.operand_one, 2);
        waitIdle();
        readReg(3'd3, rdVal);
        checkOutput("sub_dbg_r3", rdVal, 2);
        readReg(3'd4, rdVal);
        checkOutput("mul_dbg_r4", rdVal, 10);

        // Illegal opcodes 1010 and 1111
        applyStimulus(16'hA000);
        @(posedge clk);
        #1;
        checkOutput("ill_ready_next", ifc.instr_ready, 1);
        repeat (3) @(negedge clk);
        checkOutput("ill_pulse_count", illegalCount, 1);
        checkOutput("ill_alu_count", aluCount, 0);
        checkOutput("ill_wb_count", wbCount, 0);
        applyStimulus(16'hF000);
        repeat (4) @(negedge clk);
        checkOutput("ill_f_pulse_count", illegalCount, 1);
        checkOutput("ill_f_alu_count", aluCount, 0);

        // ADDI r0,r0,7 : writeback strobes but r0 stays zero
        applyStimulus(16'h1007);
        waitIdle();
        checkOutput("r0_wb_count", wbCount, 1);
        checkOutput("r0_wb_rd", wbRd, 0);
        checkOutput("r0_wb_data", wbData, 7);
        readReg(3'd0, rdVal);
        checkOutput("r0_dbg", rdVal, 0);

        // ADD r7,r1,r2 with a slow ALU: WAIT stretches, operands held to WB
        aluDelay = 3;
        applyStimulus(16'h0E50);
        waitIdle();
        aluDelay = 0;
        checkOutput("slow_wb_lat", wbCycle - acceptCycle, 5);
        checkOutput("slow_wb_op1", wbOp1, 5);
        checkOutput("slow_wb_op2", wbOp2, 3);
        readReg(3'd7, rdVal);
        checkOutput("slow_dbg_r7", rdVal, 8);

        // ADD r5,r1,r2 abandoned by reset in WAIT
        aluDelay = 20;
        applyStimulus(16'h0A50);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstwait_busy_before", ifc.busy, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstwait_busy", ifc.busy, 0);
        checkOutput("rstwait_ready", ifc.instr_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        aluDelay = 0;
        repeat (2) @(negedge clk);
        checkOutput("rstwait_wb_count", wbCount, 0);
        readReg(3'd5, rdVal);
        checkOutput("rstwait_dbg_r5", rdVal, 0);
        readReg(3'd1, rdVal);
        checkOutput("rstwait_dbg_r1", rdVal, 0);

        // DIVI r6,r1,2 then DIVI r6,r1,0
        applyStimulus(16'h1205);
        waitIdle();
        applyStimulus(16'h7C42);
        waitIdle();
        readReg(3'd6, rdVal);
        checkOutput("divi2_dbg_r6", rdVal, 2);
        applyStimulus(16'h7C40);
        waitIdle();
        repeat (2) @(negedge clk);
        readReg(3'd6, rdVal);
`ifdef EXEC_CTRL_DIV_ZERO_TRAP_EN
        checkOutput("div0_trap_count", divZeroCount, 1);
        checkOutput("div0_alu_count", aluCount, 0);
        checkOutput("div0_wb_count", wbCount, 0);
        checkOutput("div0_dbg_r6", rdVal, 2);
`else
        checkOutput("div0_alu_count", aluCount, 1);
        checkOutput("div0_wb_data", wbData, 16'hFFFF);
        checkOutput("div0_dbg_r6", rdVal, 16'hFFFF);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 Parameter NREGS, default 8, meaning the number of 16-bit architectural registers; it SHALL be fixed at 8, addressed by a 3-bit field.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 instr  input  16  instruction word: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
REQ-005 instr_valid  input  1  instruction offered; instr_ready  output  1  block can accept.
REQ-006 alu_enable  output  1  one-cycle issue strobe to the ALU.
REQ-007 opcode  output  4  ALU opcode; operand_one, operand_two  outputs  16  ALU operands.
REQ-008 result  input  16  ALU result; alu_done  input  1  ALU completion flag.
REQ-009 wb_valid  output  1  writeback strobe; wb_rd  output  3  destination; wb_data  output  16  written value.
REQ-010 illegal  output  1  one-cycle pulse on an unsupported opcode; busy  output  1  high whenever state is not IDLE.
REQ-011 dbg_addr  input  3  debug register select; dbg_data  output  16  combinational register-file read.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, WAIT, WB; instr_ready SHALL equal (state==IDLE).
REQ-013 IDLE: on instr_valid&&instr_ready the instruction SHALL be latched and the FSM SHALL go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-014 Supported opcodes: 0000-0111 and 1011-1110; opcodes 1000, 1001, 1010 and 1111 SHALL pulse illegal for one cycle in ISSUE, SHALL NOT assert alu_enable, SHALL NOT write, and SHALL return the FSM to IDLE.
REQ-015 ISSUE: alu_enable SHALL be 1 for exactly one cycle; opcode SHALL be the latched opcode; operand_one SHALL be reg[rs1].
REQ-016 operand_two SHALL be {10'b0, imm6} for odd opcodes 0001/0011/0101/0111, and reg[rs2] otherwise (including NOT, where the ALU ignores it).
REQ-017 Operands SHALL be registered outputs held stable from ISSUE through WB.
REQ-018 WAIT: the FSM SHALL stay until alu_done==1, then go to WB; WAIT SHALL last at least one cycle.
REQ-019 WB: wb_valid SHALL be 1 for one cycle, with wb_data=result and wb_rd=rd; reg[rd] SHALL be written at the closing edge; the FSM SHALL then go to IDLE.
REQ-020 reg[0] SHALL read as 0; writes to rd=0 SHALL be discarded, but wb_valid SHALL still pulse.
REQ-021 Nominal latency SHALL be accept edge -> ISSUE -> WAIT -> WB -> IDLE, i.e. 4 cycles per instruction; instructions SHALL NOT overlap.
REQ-022 A read of reg[rd] by the next instruction SHALL return the written value, since writeback completes before the next accept.
REQ-023 instr_valid activity outside IDLE SHALL be ignored.

Reset
REQ-024 While reset is high, the FSM SHALL be in IDLE, all register-file entries SHALL be 0, and alu_enable, wb_valid, illegal and busy SHALL be 0; opcode, operand_one, operand_two, wb_rd and wb_data SHALL be 0; instr_ready SHALL be 1.
REQ-025 Reset asserted mid-instruction SHALL abandon the instruction with no register write, regardless of state.

Configuration
REQ-026 Macro EXEC_CTRL_DIV_ZERO_TRAP_EN: when defined, DIV/DIVI (0110/0111) with operand_two==0 SHALL NOT issue; in ISSUE the block SHALL pulse output div_zero (1 bit, reset 0) for one cycle, skip the write, and return to IDLE.
REQ-027 When EXEC_CTRL_DIV_ZERO_TRAP_EN is undefined, the div_zero port SHALL be absent and divide-by-zero SHALL issue and write back the ALU result unchanged.

Verification
REQ-028 Reset, then ADDI r1,r0,5 -> alu_enable one cycle after accept with operands 0 and 5; wb_valid 3 cycles after accept with rd=1 and data 5; dbg r1=5.
REQ-029 r1=5, r2=3: SUB r3,r1,r2, then MUL r4,r3,r1 back-to-back -> r3=2, r4=10; second accept exactly 4 cycles after the first.
REQ-030 Opcode 1010 -> illegal pulses once, no alu_enable, no wb_valid, instr_ready high again the next cycle.
REQ-031 ADDI r0,r0,7 -> wb_valid with wb_data 7; dbg r0=0.
REQ-032 Reset asserted during WAIT of ADD r5,r1,r2 -> r5 stays 0, busy=0, instr_ready=1.
REQ-033 DIVI r6,r1,0 -> with macro defined: div_zero pulses, no alu_enable, r6 unchanged; without macro: ALU issued and r6 takes the ALU output.
